program_loader: RTL and testbench

//   Writer side of the instruction-memory interface: receives a byte stream, assembles
//   big-endian 32-bit instruction words and writes them to consecutive word addresses

---
 rtl/program_loader.sv | 143 ++++++++++++++
 tb/tb_program_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Instruction-memory loader: takes a length-prefixed byte stream, packs big-endian
// 32-bit words into consecutive word addresses and keeps the CPU held until loading completes.
module program_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    // One bit wider than len so that a full-capacity length compares correctly.
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

    logic [2:0]            state_reg, state_next;
    logic [15:0]           len_reg, len_next;
    logic [ADDR_WIDTH-1:0] word_idx_reg, word_idx_next;
    logic [1:0]            byte_cnt_reg, byte_cnt_next;
    logic [23:0]           shift_reg, shift_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic [15:0]           loaded_reg, loaded_next;

    logic        take;
    logic [15:0] len_full;
    logic        last_word;

    assign in_ready  = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) || (state_reg == S_DATA);
    assign take      = in_valid && in_ready;
    assign len_full  = {len_reg[15:8], in_data};
    assign last_word = (16'(word_idx_reg) == (len_reg - 16'd1));

    assign imem_we      = (state_reg == S_WRITE);
    assign imem_addr    = addr_reg;
    assign imem_wdata   = wdata_reg;
    assign done         = (state_reg == S_DONE);
    assign error        = (state_reg == S_ERROR);
    assign cpu_hold     = (state_reg != S_DONE);
    assign words_loaded = loaded_reg;

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        word_idx_next = word_idx_reg;
        byte_cnt_next = byte_cnt_reg;
        shift_next    = shift_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        loaded_next   = loaded_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_next  = S_LEN_HI;
                    loaded_next = 16'd0;
                end
            end
            S_LEN_HI: begin
                if (take) begin
                    len_next[15:8] = in_data;
                    state_next     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (take) begin
                    len_next = len_full;
                    if (len_full == 16'd0) begin
                        state_next = S_DONE;
                    end else if ({1'b0, len_full} > CAPACITY) begin
                        state_next = S_ERROR;
                    end else begin
                        state_next    = S_DATA;
                        word_idx_next = '0;
                        byte_cnt_next = 2'd0;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    if (byte_cnt_reg == 2'd3) begin
                        // Address and word are captured here so they hold after the write pulse.
                        addr_next  = word_idx_reg;
                        wdata_next = {shift_reg, in_data};
                        state_next = S_WRITE;
                    end else begin
                        shift_next    = {shift_reg[15:0], in_data};
                        byte_cnt_next = byte_cnt_reg + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                loaded_next = loaded_reg + 16'd1;
                if (last_word) begin
                    state_next = S_DONE;
                end else begin
                    word_idx_next = word_idx_reg + 1'b1;
                    byte_cnt_next = 2'd0;
                    state_next    = S_DATA;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            len_reg      <= 16'd0;
            word_idx_reg <= '0;
            byte_cnt_reg <= 2'd0;
            shift_reg    <= 24'd0;
            addr_reg     <= '0;
            wdata_reg    <= 32'd0;
            loaded_reg   <= 16'd0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            word_idx_reg <= word_idx_next;
            byte_cnt_reg <= byte_cnt_next;
            shift_reg    <= shift_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            loaded_reg   <= loaded_next;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives length-prefixed byte streams and checks
// writes, handshake, status outputs and reset behaviour against hand-computed values.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed write port activity, captured mid-cycle.
    logic [31:0] mem [256];
    int          wr_count = 0;
    int          ready_in_write = 0;
    int          double_we = 0;
    logic        prev_we = 1'b0;
    logic [7:0]  last_addr = 8'd0;

    program_loader #(.ADDR_WIDTH(8)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        prev_we <= imem_we;
        if (imem_we) begin
            wr_count       <= wr_count + 1;
            mem[imem_addr] <= imem_wdata;
            last_addr      <= imem_addr;
            if (in_ready) ready_in_write <= ready_in_write + 1;
            if (prev_we) double_we <= double_we + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one byte and holds it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte %h never accepted", b);
        end
    endtask

    int wr_base;
    int bad_words;
    logic [7:0]  w8;
    logic [31:0] exp_word;
    logic [7:0]  stream2 [10];

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        stream2  = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01};
        tick();
        tick();

        // 1: reset values
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd0);
        $display("T1 reset checked");

        // 2: two-word load, back-to-back bytes
        wr_base = wr_count;
        pulse_start();
        for (int i = 0; i < 6; i++) send(stream2[i]);
        check("t2_w0_we", 32'(imem_we), 32'd1);
        check("t2_w0_addr", 32'(imem_addr), 32'd0);
        check("t2_w0_data", imem_wdata, 32'hDEADBEEF);
        check("t2_w0_ready", 32'(in_ready), 32'd0);
        for (int i = 6; i < 10; i++) send(stream2[i]);
        check("t2_w1_we", 32'(imem_we), 32'd1);
        check("t2_w1_addr", 32'(imem_addr), 32'd1);
        check("t2_w1_data", imem_wdata, 32'h00000001);
        check("t2_w1_hold", 32'(cpu_hold), 32'd1);
        tick();
        check("t2_done", 32'(done), 32'd1);
        check("t2_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t2_words_loaded", 32'(words_loaded), 32'd2);
        check("t2_we_after", 32'(imem_we), 32'd0);
        check("t2_addr_hold", 32'(imem_addr), 32'd1);
        check("t2_wdata_hold", imem_wdata, 32'h00000001);
        check("t2_wr_count", 32'(wr_count - wr_base), 32'd2);
        check("t2_mem0", mem[0], 32'hDEADBEEF);
        check("t2_mem1", mem[1], 32'h00000001);
        $display("T2 two-word load checked");

        // 3: zero-length load
        wr_base = wr_count;
        pulse_start();
        check("t3_restart_done", 32'(done), 32'd0);
        check("t3_restart_hold", 32'(cpu_hold), 32'd1);
        check("t3_restart_wl", 32'(words_loaded), 32'd0);
        send(8'h00);
        send(8'h00);
        check("t3_done", 32'(done), 32'd1);
        check("t3_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t3_no_writes", 32'(wr_count - wr_base), 32'd0);
        check("t3_words_loaded", 32'(words_loaded), 32'd0);
        $display("T3 zero-length load checked");

        // 4: oversize length then full-capacity load
        wr_base = wr_count;
        pulse_start();
        send(8'h01);
        send(8'h01);
        check("t4_error", 32'(error), 32'd1);
        check("t4_err_hold", 32'(cpu_hold), 32'd1);
        check("t4_err_done", 32'(done), 32'd0);
        check("t4_err_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        check("t4_err_stays", 32'(error), 32'd1);
        check("t4_err_no_writes", 32'(wr_count - wr_base), 32'd0);
        pulse_start();
        check("t4_err_cleared", 32'(error), 32'd0);
        send(8'h01);
        send(8'h00);
        for (int k = 0; k < 1024; k++) begin
            w8 = 8'(k / 4);
            case (k % 4)
                0: send(w8);
                1: send(8'hA5);
                2: send(~w8);
                default: send(w8 ^ 8'h3C);
            endcase
        end
        check("t4_last_addr", 32'(imem_addr), 32'hFF);
        tick();
        check("t4_done", 32'(done), 32'd1);
        check("t4_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t4_words_loaded", 32'(words_loaded), 32'd256);
        check("t4_wr_count", 32'(wr_count - wr_base), 32'd256);
        check("t4_last_logged", 32'(last_addr), 32'hFF);
        bad_words = 0;
        for (int i = 0; i < 256; i++) begin
            w8 = 8'(i);
            exp_word = {w8, 8'hA5, ~w8, w8 ^ 8'h3C};
            if (mem[i] !== exp_word) bad_words++;
        end
        check("t4_mem_contents", 32'(bad_words), 32'd0);
        check("t4_mem_ff", mem[255], 32'hFF_A5_00_C3);
        $display("T4 error and full-capacity load checked");

        // 5: two-word load with idle cycles between bytes; start during DATA is ignored
        wr_base = wr_count;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) start = 1'b1;
            send(stream2[i]);
            start = 1'b0;
            if (i == 5) begin
                check("t5_w0_addr", 32'(imem_addr), 32'd0);
                check("t5_w0_data", imem_wdata, 32'hDEADBEEF);
            end
            if (i != 9) tick();
        end
        check("t5_w1_we", 32'(imem_we), 32'd1);
        check("t5_w1_data", imem_wdata, 32'h00000001);
        tick();
        check("t5_done", 32'(done), 32'd1);
        check("t5_words_loaded", 32'(words_loaded), 32'd2);
        check("t5_wr_count", 32'(wr_count - wr_base), 32'd2);
        check("t5_mem0", mem[0], 32'hDEADBEEF);
        check("t5_mem1", mem[1], 32'h00000001);
        check("t5_ready_in_write", 32'(ready_in_write), 32'd0);
        check("t5_double_we", 32'(double_we), 32'd0);
        $display("T5 gapped load checked");

        // 6: reset mid-load, then a fresh one-word load
        wr_base = wr_count;
        pulse_start();
        send(8'h00);
        send(8'h01);
        send(8'hDE);
        send(8'hAD);
        reset_n = 1'b0;
        #1;
        check("t6_rst_hold", 32'(cpu_hold), 32'd1);
        check("t6_rst_ready", 32'(in_ready), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_wl", 32'(words_loaded), 32'd0);
        check("t6_rst_addr", 32'(imem_addr), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("t6_idle_ready", 32'(in_ready), 32'd0);
        check("t6_no_partial_write", 32'(wr_count - wr_base), 32'd0);
        pulse_start();
        send(8'h00);
        send(8'h01);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        check("t6_we", 32'(imem_we), 32'd1);
        check("t6_addr", 32'(imem_addr), 32'd0);
        check("t6_data", imem_wdata, 32'h11223344);
        tick();
        check("t6_done", 32'(done), 32'd1);
        check("t6_words_loaded", 32'(words_loaded), 32'd1);
        check("t6_mem0", mem[0], 32'h11223344);
        check("t6_mem1_kept", mem[1], 32'h00000001);
        $display("T6 reset mid-load checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
